// File: rtl/fru_pla_cfg_loader.sv
// Serial configuration loader for the FruSelect PLA: shifts a parity-protected
// frame into a shadow register and commits it atomically on good even parity.
module fru_pla_cfg_loader #(
  parameter int INPUT_SIZE   = 2,
  parameter int OUTPUT_SIZE  = 4,
  parameter int SEGMENT_SIZE = 2
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                CfgStart,
  input  logic                                                CfgValid,
  input  logic                                                CfgBit,
  output logic                                                CfgReady,
  output logic                                                CfgBusy,
  output logic                                                CfgDone,
  output logic                                                CfgError,
  output logic [OUTPUT_SIZE-1:0][$clog2(INPUT_SIZE)-1:0]      RegMux,
  output logic [OUTPUT_SIZE-1:0][(2**SEGMENT_SIZE)-1:0]       RegMintermORSelect
);

  localparam int MUX_W  = $clog2(INPUT_SIZE);
  localparam int MT_W   = 2**SEGMENT_SIZE;
  localparam int TOTAL  = OUTPUT_SIZE*(MUX_W+MT_W);
  localparam int MUX_T  = OUTPUT_SIZE*MUX_W;
  localparam int MT_T   = OUTPUT_SIZE*MT_W;
  localparam int CNT_W  = $clog2(TOTAL+2);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [CNT_W-1:0]                    r_cnt;
  logic                                r_par;
  logic [TOTAL-1:0]                    r_shadow;
  logic                                r_done;
  logic                                r_err;
  logic [OUTPUT_SIZE-1:0][MUX_W-1:0]   r_mux;
  logic [OUTPUT_SIZE-1:0][MT_W-1:0]    r_mt;
  logic                                w_accept;
  logic                                w_last;
  logic                                w_restart;

  // A start pulse outranks a coincident bit, so the bit is never accepted.
  assign w_accept  = (r_state == ST_SHIFT) && CfgValid && !CfgStart;
  assign w_last    = w_accept && (r_cnt == LAST_IDX);
  assign w_restart = CfgStart && (r_state != ST_COMMIT);

  assign CfgReady           = (r_state == ST_SHIFT);
  assign CfgBusy            = (r_state != ST_IDLE);
  assign CfgDone            = r_done;
  assign CfgError           = r_err;
  assign RegMux             = r_mux;
  assign RegMintermORSelect = r_mt;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (CfgStart) begin
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (CfgStart) begin
          w_state_nxt = ST_SHIFT;
        end else if (w_last) begin
          w_state_nxt = ST_COMMIT;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath, committed configuration and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_par    <= 1'b0;
      r_shadow <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_mux    <= '0;
      r_mt     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_restart) begin
        r_cnt    <= '0;
        r_par    <= 1'b0;
        r_shadow <= '0;
        r_err    <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_par <= r_par ^ CfgBit;
        // The parity bit only feeds the running parity, never the shadow.
        if (r_cnt < LAST_IDX) begin
          r_shadow <= {r_shadow[TOTAL-2:0], CfgBit};
        end
      end else if (r_state == ST_COMMIT) begin
        if (r_par == 1'b0) begin
          r_mux  <= r_shadow[TOTAL-1 -: MUX_T];
          r_mt   <= r_shadow[MT_T-1:0];
          r_done <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

endmodule
